// File: rtl/seg_pkg.sv
// Shared BCD types and helpers for the display counter and decode path.
package seg_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   function automatic logic is_bcd(input bcd_t v);
      return (v <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain: load, increment/decrement with carry/borrow out.
module bcd_digit
   import seg_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic ld,
   input  bcd_t ld_val,
   input  logic step_en,
   input  logic up,
   input  logic cin,
   output bcd_t digit,
   output logic cout
);

   // Carry when rolling 9->0 going up, borrow when rolling 0->9 going down.
   assign cout = cin && (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

   always_ff @(posedge clk) begin
      if (reset) begin
         digit <= BCD_MIN;
      end else if (ld) begin
         digit <= ld_val;
      end else if (step_en && cin) begin
         if (up) begin
            digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
         end else begin
            digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit up/down BCD counter stepped by an on-clock prescaler enable.
module bcd_tick_counter
   import seg_pkg::*;
#(
   parameter int NDIG = 4,
   parameter int DIV  = 50_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              up,
   input  logic              load,
   input  logic [4*NDIG-1:0] load_val,
   output logic [4*NDIG-1:0] digits,
   output logic              tick,
   output logic              wrap
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);

   logic [PW-1:0]     presc;
   logic              step_p0;
   logic              tick_p1;
   logic              wrap_p1;
   logic [NDIG:0]     carry;
   logic [4*NDIG-1:0] ld_clean;

   // A load on the terminal prescaler edge wins, so no step is taken then.
   assign step_p0 = en && (presc == PRESC_TOP) && !load;

   always_ff @(posedge clk) begin
      if (reset || load) begin
         presc <= '0;
      end else if (en) begin
         presc <= (presc == PRESC_TOP) ? '0 : presc + PW'(1);
      end
   end

   always_comb begin
      ld_clean = '0;
      for (int k = 0; k < NDIG; k++) begin
         ld_clean[4*k +: 4] = is_bcd(load_val[4*k +: 4]) ? load_val[4*k +: 4] : BCD_MIN;
      end
   end

   assign carry[0] = step_p0;

   for (genvar k = 0; k < NDIG; k++) begin : g_dig
      bcd_digit u_dig (
         .clk     (clk),
         .reset   (reset),
         .ld      (load),
         .ld_val  (ld_clean[4*k +: 4]),
         .step_en (step_p0),
         .up      (up),
         .cin     (carry[k]),
         .digit   (digits[4*k +: 4]),
         .cout    (carry[k+1])
      );
   end

   // stage p0 -> p1: pulses line up with the updated digits
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_p1 <= 1'b0;
         wrap_p1 <= 1'b0;
      end else begin
         tick_p1 <= step_p0;
         wrap_p1 <= carry[NDIG];
      end
   end

   assign tick = tick_p1;
   assign wrap = wrap_p1;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with NDIG=4, DIV=4.
module tb_bcd_tick_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        up;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] digits;
   logic        tick;
   logic        wrap;

   int n_cmp = 0;
   int n_bad = 0;
   logic wrap_seen;

   bcd_tick_counter #(.NDIG(4), .DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .digits   (digits),
      .tick     (tick),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
      cyc(2);
      chk("rst_digits", 32'(digits), 32'h0000);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);

      // Test 1: count up from zero
      reset = 1'b0; en = 1'b1; up = 1'b1;
      wrap_seen = 1'b0;
      for (int i = 1; i <= 44; i++) begin
         cyc(1);
         if (wrap) wrap_seen = 1'b1;
         case (i)
            3: begin
               chk("t1_c3_digits", 32'(digits), 32'h0000);
               chk("t1_c3_tick", 32'(tick), 32'h0);
            end
            4: begin
               chk("t1_c4_digits", 32'(digits), 32'h0001);
               chk("t1_c4_tick", 32'(tick), 32'h1);
            end
            5: chk("t1_c5_tick", 32'(tick), 32'h0);
            40: begin
               chk("t1_c40_digits", 32'(digits), 32'h0010);
               chk("t1_c40_tick", 32'(tick), 32'h1);
            end
            44: chk("t1_c44_digits", 32'(digits), 32'h0011);
            default: ;
         endcase
      end
      chk("t1_no_wrap", 32'(wrap_seen), 32'h0);

      // Test 2: load near the top and roll over upward
      load = 1'b1; load_val = 16'h9998;
      cyc(1);
      load = 1'b0;
      chk("t2_load_digits", 32'(digits), 32'h9998);
      chk("t2_load_tick", 32'(tick), 32'h0);
      cyc(3);
      chk("t2_hold_digits", 32'(digits), 32'h9998);
      cyc(1);
      chk("t2_9999_digits", 32'(digits), 32'h9999);
      chk("t2_9999_tick", 32'(tick), 32'h1);
      chk("t2_9999_wrap", 32'(wrap), 32'h0);
      cyc(4);
      chk("t2_roll_digits", 32'(digits), 32'h0000);
      chk("t2_roll_tick", 32'(tick), 32'h1);
      chk("t2_roll_wrap", 32'(wrap), 32'h1);
      cyc(1);
      chk("t2_after_tick", 32'(tick), 32'h0);
      chk("t2_after_wrap", 32'(wrap), 32'h0);

      // Test 3: count down through zero
      reset = 1'b1;
      cyc(1);
      reset = 1'b0; up = 1'b0;
      chk("t3_rst_digits", 32'(digits), 32'h0000);
      cyc(4);
      chk("t3_down_digits", 32'(digits), 32'h9999);
      chk("t3_down_wrap", 32'(wrap), 32'h1);
      cyc(4);
      chk("t3_down2_digits", 32'(digits), 32'h9998);
      chk("t3_down2_wrap", 32'(wrap), 32'h0);
      chk("t3_down2_tick", 32'(tick), 32'h1);

      // Test 4: enable freeze holds the prescaler
      cyc(2);
      en = 1'b0;
      cyc(10);
      chk("t4_frozen_digits", 32'(digits), 32'h9998);
      chk("t4_frozen_tick", 32'(tick), 32'h0);
      en = 1'b1;
      cyc(1);
      chk("t4_resume1_tick", 32'(tick), 32'h0);
      cyc(1);
      chk("t4_resume2_digits", 32'(digits), 32'h9997);
      chk("t4_resume2_tick", 32'(tick), 32'h1);

      // Test 5: sanitised load, and load on a step edge
      up = 1'b1;
      load = 1'b1; load_val = 16'h12A4;
      cyc(1);
      load = 1'b0;
      chk("t5_sanit_digits", 32'(digits), 32'h1204);
      chk("t5_sanit_tick", 32'(tick), 32'h0);
      cyc(3);
      load = 1'b1; load_val = 16'h0567;
      cyc(1);
      load = 1'b0;
      chk("t5_ldstep_digits", 32'(digits), 32'h0567);
      chk("t5_ldstep_tick", 32'(tick), 32'h0);
      chk("t5_ldstep_wrap", 32'(wrap), 32'h0);
      cyc(3);
      chk("t5_wait_digits", 32'(digits), 32'h0567);
      chk("t5_wait_tick", 32'(tick), 32'h0);
      cyc(1);
      chk("t5_next_digits", 32'(digits), 32'h0568);
      chk("t5_next_tick", 32'(tick), 32'h1);

      // Test 6: mid-count reset pulse
      cyc(2);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("t6_rst_digits", 32'(digits), 32'h0000);
      chk("t6_rst_tick", 32'(tick), 32'h0);
      chk("t6_rst_wrap", 32'(wrap), 32'h0);
      cyc(3);
      chk("t6_wait_tick", 32'(tick), 32'h0);
      chk("t6_wait_digits", 32'(digits), 32'h0000);
      cyc(1);
      chk("t6_first_digits", 32'(digits), 32'h0001);
      chk("t6_first_tick", 32'(tick), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
